// File: rtl/rr_resource_scheduler.sv
// Round-robin scheduler for one shared multi-cycle execution resource.
// Picks a requester, launches the resource with its operand, and holds the
// grant until the resource reports done or the watchdog expires.
module rr_resource_scheduler #(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N-1:0]    req_i,
  input  logic [32*N-1:0] req_data_i,
  input  logic            done_i,
  output logic [N-1:0]    grant_o,
  output logic [2:0]      grant_id_o,
  output logic            res_start_o,
  output logic [31:0]     res_data_o,
  output logic            busy_o,
  output logic            timeout_err_o
);

  typedef enum logic [1:0] {StIdle, StStart, StWait} state_e;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);
  localparam logic [2:0] LastId      = 3'(N - 1);

  state_e      state_q;
  logic [N-1:0] grant_q;
  logic [2:0]  grant_id_q;
  logic        res_start_q;
  logic [31:0] res_data_q;
  logic        busy_q;
  logic        timeout_err_q;
  logic [2:0]  ptr_q;
  logic [2:0]  ptr_d;
  logic [7:0]  wait_cnt_q;

  logic         win_found;
  logic [2:0]   win_id;
  logic [N-1:0] win_onehot;
  logic [31:0]  win_data;

  // Winner search: lowest requester at or above ptr, else lowest below ptr.
  // First pass takes any requester, second pass overrides with one >= ptr.
  always_comb begin
    win_found  = 1'b0;
    win_id     = 3'd0;
    win_onehot = '0;
    win_data   = 32'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        win_found     = 1'b1;
        win_id        = 3'(i);
        win_onehot    = '0;
        win_onehot[i] = 1'b1;
        win_data      = req_data_i[32*i +: 32];
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i] && (i >= int'(ptr_q))) begin
        win_found     = 1'b1;
        win_id        = 3'(i);
        win_onehot    = '0;
        win_onehot[i] = 1'b1;
        win_data      = req_data_i[32*i +: 32];
      end
    end
  end

  // Pointer moves just past the requester whose grant is ending.
  always_comb begin
    ptr_d = (grant_id_q == LastId) ? 3'd0 : grant_id_q + 3'd1;
  end

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      grant_id_q    <= 3'd0;
      res_start_q   <= 1'b0;
      res_data_q    <= 32'd0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      ptr_q         <= 3'd0;
      wait_cnt_q    <= 8'd0;
    end else begin
      timeout_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            state_q     <= StStart;
            grant_q     <= win_onehot;
            grant_id_q  <= win_id;
            res_start_q <= 1'b1;
            res_data_q  <= win_data;
            busy_q      <= 1'b1;
          end
        end
        StStart: begin
          res_start_q <= 1'b0;
          wait_cnt_q  <= 8'd0;
          state_q     <= StWait;
        end
        StWait: begin
          wait_cnt_q <= wait_cnt_q + 8'd1;
          if (done_i || (wait_cnt_q == TimeoutLast)) begin
            grant_q       <= '0;
            busy_q        <= 1'b0;
            ptr_q         <= ptr_d;
            state_q       <= StIdle;
            // done takes priority over a coincident watchdog expiry
            timeout_err_q <= ~done_i;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant_o       = grant_q;
  assign grant_id_o    = grant_id_q;
  assign res_start_o   = res_start_q;
  assign res_data_o    = res_data_q;
  assign busy_o        = busy_q;
  assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_rr_resource_scheduler.sv
// Directed bench for rr_resource_scheduler (N=4, TIMEOUT=16).
module tb_rr_resource_scheduler;

  localparam int unsigned N       = 4;
  localparam int unsigned TIMEOUT = 16;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [32*N-1:0] req_data;
  logic            done;
  logic [N-1:0]    grant;
  logic [2:0]      grant_id;
  logic            res_start;
  logic [31:0]     res_data;
  logic            busy;
  logic            timeout_err;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int held   = 0;

  rr_resource_scheduler #(
    .N      (N),
    .TIMEOUT(TIMEOUT)
  ) u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (req),
    .req_data_i   (req_data),
    .done_i       (done),
    .grant_o      (grant),
    .grant_id_o   (grant_id),
    .res_start_o  (res_start),
    .res_data_o   (res_data),
    .busy_o       (busy),
    .timeout_err_o(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full grant: launch, START, `waits` idle WAIT cycles, then done.
  task automatic serve(input int exp_id, input int waits, input logic [31:0] exp_data);
    logic [N-1:0] oh;
    oh = '0;
    oh[exp_id] = 1'b1;
    step();
    chk("launch_grant_id", 64'(grant_id), 64'(exp_id));
    chk("launch_grant", 64'(grant), 64'(oh));
    chk("launch_res_start", 64'(res_start), 64'd1);
    chk("launch_res_data", 64'(res_data), 64'(exp_data));
    chk("launch_busy", 64'(busy), 64'd1);
    step();
    chk("start_fall", 64'(res_start), 64'd0);
    chk("wait_grant", 64'(grant), 64'(oh));
    repeat (waits) step();
    done = 1'b1;
    step();
    done = 1'b0;
    chk("release_grant", 64'(grant), 64'd0);
    chk("release_busy", 64'(busy), 64'd0);
    chk("release_terr", 64'(timeout_err), 64'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    done     = 1'b0;
    req_data = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
    #12;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_res_start", 64'(res_start), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_terr", 64'(timeout_err), 64'd0);
    rst_n = 1'b1;

    // Fairness: all requesting, one grant per 3 cycles.
    req = 4'b1111;
    serve(0, 0, 32'hDEAD_BEEF);
    serve(1, 0, 32'h1111_1111);
    serve(2, 0, 32'h2222_2222);
    serve(3, 0, 32'h3333_3333);
    serve(0, 0, 32'hDEAD_BEEF);

    // Single requester 0 with a slower resource; ptr now 1.
    req = 4'b0001;
    serve(0, 2, 32'hDEAD_BEEF);
    // ptr=1: requester 1 wins over 0.
    req = 4'b0011;
    serve(1, 0, 32'h1111_1111);

    // Grant to 2 leaves ptr=3, then wrap to 0 and skip to 2.
    req = 4'b0100;
    serve(2, 0, 32'h2222_2222);
    req = 4'b0101;
    serve(0, 0, 32'hDEAD_BEEF);
    serve(2, 0, 32'h2222_2222);

    // Watchdog: ptr=3, requester 3 never gets done.
    req  = 4'b1001;
    held = 0;
    step();
    chk("to_launch_id", 64'(grant_id), 64'd3);
    for (int i = 0; i < 17; i++) begin
      if (grant == 4'b1000) held++;
      if (i < 16) step();
    end
    chk("to_held_cycles", 64'(held), 64'd17);
    chk("to_no_early_err", 64'(timeout_err), 64'd0);
    step();
    chk("to_release_grant", 64'(grant), 64'd0);
    chk("to_err_pulse", 64'(timeout_err), 64'd1);
    chk("to_release_busy", 64'(busy), 64'd0);
    // Next requester (ptr=0) launched after the idle cycle.
    step();
    chk("to_err_single", 64'(timeout_err), 64'd0);
    chk("to_next_id", 64'(grant_id), 64'd0);
    req = 4'b0000;
    // done coincides with the final watchdog cycle.
    step();
    repeat (TIMEOUT - 1) step();
    chk("co_still_held", 64'(grant), 64'd1);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("co_release", 64'(grant), 64'd0);
    chk("co_no_err", 64'(timeout_err), 64'd0);

    // Stability: ptr=1, operand and req change during WAIT.
    req = 4'b0010;
    step();
    chk("st_launch_id", 64'(grant_id), 64'd1);
    step();
    req_data[63:32] = 32'hCAFE_F00D;
    req = 4'b0000;
    step();
    chk("st_res_data", 64'(res_data), 64'h1111_1111);
    chk("st_grant", 64'(grant), 64'b0010);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("st_release", 64'(grant), 64'd0);
    chk("st_res_data_kept", 64'(res_data), 64'h1111_1111);
    req_data[63:32] = 32'h1111_1111;

    // Reset mid-WAIT: ptr=2, grant requester 2, then async reset.
    req = 4'b0100;
    step();
    chk("rw_launch_id", 64'(grant_id), 64'd2);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rw_grant_async", 64'(grant), 64'd0);
    chk("rw_busy_async", 64'(busy), 64'd0);
    chk("rw_start_async", 64'(res_start), 64'd0);
    req  = 4'b0010;
    done = 1'b1;
    #2;
    rst_n = 1'b1;
    step();
    done = 1'b0;
    chk("rw_after_id", 64'(grant_id), 64'd1);
    chk("rw_after_grant", 64'(grant), 64'b0010);
    chk("rw_after_data", 64'(res_data), 64'h1111_1111);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rr_resource_scheduler.md
# rr_resource_scheduler

Round-robin scheduler that shares one multi-cycle execution resource among N requesters. It is a small explicit state machine of the kind our generated FSM modules produce. It picks one requester, launches the resource with that requester's 32-bit operand, and holds the grant until the resource signals completion or a watchdog timeout expires. It sits between the per-client request logic and the shared datapath unit and is the only block that drives that unit's start strobe.

## Interface
- N, 4, number of requesters (2..8)
- TIMEOUT, 16, maximum cycles spent in WAIT before the grant is forcibly released (1..255)
- clk  input  1  clock; all state updates on posedge
- reset  input  1  asynchronous, active-low; reset == 0 forces the reset state immediately
- req  input  N  per-requester request level; bit i belongs to requester i
- req_data  input  32*N  operands; requester i occupies bits [32*i+31 : 32*i]
- done  input  1  resource completion pulse; sampled only in WAIT
- grant  output  N  one-hot grant, registered; all zero when idle
- grant_id  output  3  index of the granted requester, registered; valid while grant != 0
- res_start  output  1  single-cycle launch strobe to the resource, registered
- res_data  output  32  operand latched at launch; held stable until the next launch
- busy  output  1  high in START and WAIT
- timeout_err  output  1  single-cycle pulse when the watchdog fires

## Operation
- Reset (reset == 0): state = IDLE, grant = 0, grant_id = 0, res_start = 0, res_data = 0, busy = 0, timeout_err = 0, ptr = 0, wait_cnt = 0.
- Round-robin pointer ptr: the first requester checked is ptr, then ptr+1, ... wrapping mod N. After a grant to index k ends, ptr becomes (k+1) mod N, whether it ended by done or by timeout.
- IDLE: grant = 0, busy = 0. If req != 0, select the winner k, then at the edge:
  - state <= START, grant <= onehot(k), grant_id <= k
  - res_start <= 1, res_data <= req_data[k], busy <= 1
- START: lasts exactly one cycle with res_start high. At the edge: res_start <= 0, wait_cnt <= 0, state <= WAIT.
- WAIT: grant is held and wait_cnt increments each cycle.
  - done == 1: at the edge, grant <= 0, busy <= 0, ptr <= (k+1) mod N, state <= IDLE.
  - No done and wait_cnt == TIMEOUT-1: same release as done, plus timeout_err <= 1 for one cycle.
  - If done and the timeout condition coincide, done wins and timeout_err stays 0.
- A requester deasserting req while granted has no effect; the grant is held until done or timeout.
- req_data is sampled only at the IDLE->START edge; later changes are ignored.
- done outside WAIT is ignored.
- Width rules:
  - wait_cnt is 8 bits and saturates implicitly because TIMEOUT <= 255.
  - grant_id upper bits are zero when N < 8.

## Timing
- Request to launch latency: req is sampled high in IDLE at edge t; grant, grant_id, res_start and res_data are visible after edge t. res_start falls after edge t+1.
- Release: done is sampled at edge u and grant drops after edge u. The earliest next grant is after edge u+1, so every pair of grants has at least one idle cycle with grant == 0.
- Back-to-back throughput with a 1-cycle resource (done in the first WAIT cycle): one grant per 3 cycles.
- Watchdog: grant is held for exactly TIMEOUT+1 cycles (START + TIMEOUT WAIT cycles). timeout_err is high in the first IDLE cycle.
- Reset mid-operation: all outputs clear asynchronously and ptr returns to 0. A pending done after reset release is ignored because the state is IDLE.

## Test plan
- Single requester, N=4: req=0001, req_data[0]=0xDEADBEEF, done 3 cycles after res_start -> grant=0001 and res_data=0xDEADBEEF one cycle after req; res_start high exactly 1 cycle; grant drops the edge after done; ptr=1.
- Fairness: req=1111 held, done 1 cycle into each WAIT -> grant_id sequence 0,1,2,3,0 with a 3-cycle period and one zero-grant cycle between grants.
- Pointer wrap and skip: ptr=3 after a grant to 2, then req=0101 -> grant_id=0, then 2.
- Timeout, TIMEOUT=16, no done -> grant held 17 cycles, timeout_err pulses once, next requester is granted afterwards; a second run with done and timeout in the same cycle -> timeout_err stays 0.
- Reset during WAIT: assert reset low mid-grant -> grant, busy and res_start are 0 immediately (before the next edge); after release with req=0010 -> grant_id=1, because ptr=0 and requester 0 is not requesting.
- Stability: change req_data[k] and drop req[k] during WAIT -> res_data and grant unchanged until done.
